// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit arbiter.
package mdu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRespond
  } mdu_state_t;

  localparam int unsigned OpwDefault = 3;

  localparam logic [OpwDefault-1:0] OpMul  = 3'd0;
  localparam logic [OpwDefault-1:0] OpMulh = 3'd1;
  localparam logic [OpwDefault-1:0] OpDiv  = 3'd4;
  localparam logic [OpwDefault-1:0] OpDivu = 3'd5;
  localparam logic [OpwDefault-1:0] OpRem  = 3'd6;
  localparam logic [OpwDefault-1:0] OpRemu = 3'd7;

  // Index width that stays at least one bit wide.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mdu_arbiter_if.sv
// Requester-side and unit-side handshake bundle of the arbiter.
interface mdu_arbiter_if
  import mdu_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = OpwDefault
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*OPW-1:0]   req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic                  unit_input_valid;
  logic                  unit_ready;
  logic [OPW-1:0]        unit_op;
  logic [WIDTH-1:0]      unit_a;
  logic [WIDTH-1:0]      unit_b;
  logic                  unit_valid;
  logic                  unit_output_ready;
  logic [WIDTH-1:0]      unit_result;

  // Environment side: requesters plus the shared execution unit.
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, unit_ready, unit_valid, unit_result,
    input  req_ready, resp_valid, resp_data, unit_input_valid, unit_op, unit_a, unit_b,
           unit_output_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, unit_ready, unit_valid, unit_result,
    output req_ready, resp_valid, resp_data, unit_input_valid, unit_op, unit_a, unit_b,
           unit_output_ready
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_pick
  import mdu_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IdxW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] last_grant_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [31:0]     cand;
  logic [IdxW-1:0] cand_idx;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand     = (32'(last_grant_i) + off) % NREQ;
      cand_idx = cand[IdxW-1:0];
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mdu_arbiter.sv
// Round-robin sharing of one multi-cycle mul/div unit; one operation in flight at a time.
module mdu_arbiter
  import mdu_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = OpwDefault
) (
  input logic          clk,
  input logic          reset,
  mdu_arbiter_if.slave bus
);

  localparam int unsigned IdxW = idx_width(NREQ);

  mdu_state_t      state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] gnt_onehot;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i       (bus.req_valid),
    .last_grant_i(last_q),
    .gnt_o       (pick_gnt),
    .idx_o       (pick_idx),
    .any_o       (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A pick in IDLE is always a transfer: req_ready mirrors the pick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pick_any) state_d = StIssue;
      StIssue:   if (bus.unit_ready) state_d = StWait;
      StWait:    if (bus.unit_valid) state_d = StRespond;
      StRespond: if (bus.resp_ready[gnt_q]) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_onehot        = '0;
    gnt_onehot[gnt_q] = 1'b1;
  end

  always_comb begin
    bus.req_ready         = '0;
    bus.unit_input_valid  = 1'b0;
    bus.unit_output_ready = 1'b0;
    bus.resp_valid        = '0;
    unique case (state_q)
      StIdle:    bus.req_ready = pick_gnt;
      StIssue:   bus.unit_input_valid = 1'b1;
      StWait:    bus.unit_output_ready = 1'b1;
      StRespond: bus.resp_valid = gnt_onehot;
      default:   ;
    endcase
  end

  always_comb begin
    gnt_d  = gnt_q;
    last_d = last_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    if (state_q == StIdle && pick_any) begin
      gnt_d = pick_idx;
      op_d  = bus.req_op[pick_idx*OPW +: OPW];
      a_d   = bus.req_a[pick_idx*WIDTH +: WIDTH];
      b_d   = bus.req_b[pick_idx*WIDTH +: WIDTH];
    end
    // Results are only captured while waiting; stray unit_valid elsewhere is dropped.
    if (state_q == StWait && bus.unit_valid) begin
      res_d = bus.unit_result;
    end
    if (state_q == StRespond && bus.resp_ready[gnt_q]) begin
      last_d = gnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q  <= '0;
      last_q <= IdxW'(NREQ - 1);
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
    end
  end

  assign bus.unit_op   = op_q;
  assign bus.unit_a    = a_q;
  assign bus.unit_b    = b_q;
  assign bus.resp_data = res_q;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Scoreboard bench for mdu_arbiter: directed corner cases plus randomized traffic.
module tb_mdu_arbiter;
  import mdu_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW)) bus ();

  mdu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int               idx;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  int   grant_log[$];
  int   m_last = NREQ - 1;
  bit   auto_req = 0;
  bit   always_on = 0;
  bit   auto_unit = 0;
  bit   u_pend;
  int   u_dly;
  logic [WIDTH-1:0] u_res;
  logic [NREQ-1:0]  r_acc;
  logic [OPW-1:0]   ops[6];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] calc(logic [OPW-1:0] op, logic [WIDTH-1:0] a,
                                            logic [WIDTH-1:0] b);
    logic signed [63:0] p;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (op)
      OpMul:   return a * b;
      OpMulh: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[63:32];
      end
      OpDiv:   return (b == 0) ? 32'hffff_ffff : ovf ? a : $signed(a) / $signed(b);
      OpDivu:  return (b == 0) ? 32'hffff_ffff : a / b;
      OpRem:   return (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
      OpRemu:  return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Reference rule: first pending requester after the last served one, wrapping.
  function automatic int rr_model(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int max);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && bus.req_valid == 0) break;
      n++;
      if (n >= max) break;
    end
    check("drain_pending", 64'(sb.size()), 0);
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        m_last = NREQ - 1;
      end else begin
        int e;
        logic [NREQ-1:0] acc;
        e = (sb.size() != 0) ? -1 : rr_model(bus.req_valid, m_last);
        check("req_ready", 64'(bus.req_ready), 64'(onehot(e)));
        if (sb.size() == 0) begin
          check("unit_input_valid_idle", 64'(bus.unit_input_valid), 0);
          check("resp_valid_idle", 64'(bus.resp_valid), 0);
        end else begin
          if (bus.unit_input_valid && bus.unit_ready) begin
            check("unit_op", 64'(bus.unit_op), 64'(sb[0].op));
            check("unit_a", 64'(bus.unit_a), 64'(sb[0].a));
            check("unit_b", 64'(bus.unit_b), 64'(sb[0].b));
          end
          if (bus.resp_valid != 0) begin
            check("resp_valid_owner", 64'(bus.resp_valid), 64'(onehot(sb[0].idx)));
            if ((bus.resp_valid & bus.resp_ready) != 0) begin
              check("resp_data", 64'(bus.resp_data), 64'(sb[0].res));
              m_last = sb[0].idx;
              void'(sb.pop_front());
            end
          end
        end
        acc = bus.req_valid & bus.req_ready;
        if (acc != 0) begin
          exp_t x;
          int g;
          g     = idx_of(acc);
          x.idx = g;
          x.op  = bus.req_op[g*OPW +: OPW];
          x.a   = bus.req_a[g*WIDTH +: WIDTH];
          x.b   = bus.req_b[g*WIDTH +: WIDTH];
          x.res = calc(x.op, x.a, x.b);
          sb.push_back(x);
          grant_log.push_back(g);
        end
      end
    end
  end

  // Behavioural execution unit with random accept and answer latency.
  initial begin
    u_pend = 0;
    u_dly  = 0;
    u_res  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        u_pend = 0;
      end else if (auto_unit) begin
        if (u_pend && bus.unit_valid && bus.unit_output_ready) u_pend = 0;
        if (bus.unit_input_valid && bus.unit_ready) begin
          u_res  = calc(bus.unit_op, bus.unit_a, bus.unit_b);
          u_pend = 1;
          u_dly  = $urandom_range(0, 3);
        end
      end
      cyc();
      if (auto_unit) begin
        bus.unit_ready = ($urandom_range(0, 2) != 0);
        if (u_pend && u_dly == 0) begin
          bus.unit_valid  = 1'b1;
          bus.unit_result = u_res;
        end else if (u_pend) begin
          u_dly--;
          bus.unit_valid  = 1'b0;
          bus.unit_result = $urandom;
        end else begin
          bus.unit_valid  = ($urandom_range(0, 3) == 0);
          bus.unit_result = $urandom;
        end
      end
    end
  end

  // Requesters: drop valid once accepted (manual) or refill with random work (auto).
  initial begin
    forever begin
      @(negedge clk);
      r_acc = reset ? '0 : (bus.req_valid & bus.req_ready);
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (auto_req) begin
          if (r_acc[i] || !bus.req_valid[i]) begin
            bus.req_valid[i]             = always_on || ($urandom_range(0, 2) == 0);
            bus.req_op[i*OPW +: OPW]     = ops[$urandom_range(0, 5)];
            bus.req_a[i*WIDTH +: WIDTH]  = $urandom;
            bus.req_b[i*WIDTH +: WIDTH]  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
          end
        end else if (r_acc[i]) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      if (auto_req) bus.resp_ready = NREQ'($urandom);
    end
  end

  initial begin
    ops = '{OpMul, OpMulh, OpDiv, OpDivu, OpRem, OpRemu};
    bus.req_valid   = '0;
    bus.req_op      = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.resp_ready  = '0;
    bus.unit_ready  = 1'b0;
    bus.unit_valid  = 1'b0;
    bus.unit_result = '0;
    repeat (2) cyc();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_resp_valid", 64'(bus.resp_valid), 0);
    check("rst_uiv", 64'(bus.unit_input_valid), 0);
    check("rst_uor", 64'(bus.unit_output_ready), 0);
    check("rst_resp_data", 64'(bus.resp_data), 0);
    check("rst_unit_op", 64'(bus.unit_op), 0);
    check("rst_unit_a", 64'(bus.unit_a), 0);
    check("rst_unit_b", 64'(bus.unit_b), 0);

    // Single MUL 6*7 with a one-cycle unit.
    cyc();
    bus.req_valid           = 2'b01;
    bus.req_op[0 +: OPW]    = OpMul;
    bus.req_a[0 +: WIDTH]   = 32'd6;
    bus.req_b[0 +: WIDTH]   = 32'd7;
    bus.unit_ready          = 1'b1;
    bus.resp_ready          = 2'b01;
    @(negedge clk);
    check("t1_req_ready", 64'(bus.req_ready), 64'(2'b01));
    cyc();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_uiv", 64'(bus.unit_input_valid), 1);
    check("t1_unit_op", 64'(bus.unit_op), 64'(OpMul));
    check("t1_unit_a", 64'(bus.unit_a), 6);
    check("t1_unit_b", 64'(bus.unit_b), 7);
    cyc();
    bus.unit_ready  = 1'b0;
    bus.unit_valid  = 1'b1;
    bus.unit_result = 32'd42;
    @(negedge clk);
    check("t1_uor", 64'(bus.unit_output_ready), 1);
    check("t1_uiv_off", 64'(bus.unit_input_valid), 0);
    cyc();
    bus.unit_valid = 1'b0;
    @(negedge clk);
    check("t1_resp_valid", 64'(bus.resp_valid), 64'(2'b01));
    check("t1_resp_data", 64'(bus.resp_data), 42);
    cyc();
    @(negedge clk);
    check("t1_back_idle", 64'(bus.resp_valid), 0);

    // Issue stall with unit_ready low, then held response on requester 1.
    cyc();
    bus.resp_ready                 = 2'b00;
    bus.req_valid                  = 2'b10;
    bus.req_op[OPW +: OPW]         = OpDivu;
    bus.req_a[WIDTH +: WIDTH]      = 32'd100;
    bus.req_b[WIDTH +: WIDTH]      = 32'd7;
    bus.req_op[0 +: OPW]           = OpMul;
    bus.req_a[0 +: WIDTH]          = 32'd3;
    bus.req_b[0 +: WIDTH]          = 32'd5;
    @(negedge clk);
    check("t3_req_ready", 64'(bus.req_ready), 64'(2'b10));
    cyc();
    bus.req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_uiv_hold", 64'(bus.unit_input_valid), 1);
      check("t3_a_hold", 64'(bus.unit_a), 100);
      check("t3_b_hold", 64'(bus.unit_b), 7);
      check("t3_no_accept", 64'(bus.req_ready), 0);
      cyc();
    end
    bus.unit_ready = 1'b1;
    @(negedge clk);
    check("t3_uiv_last", 64'(bus.unit_input_valid), 1);
    cyc();
    bus.unit_ready  = 1'b0;
    bus.unit_valid  = 1'b1;
    bus.unit_result = 32'd14;
    @(negedge clk);
    check("t3_uor", 64'(bus.unit_output_ready), 1);
    cyc();
    bus.unit_valid = 1'b0;
    bus.resp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_resp_hold", 64'(bus.resp_valid), 64'(2'b10));
      check("t4_data_hold", 64'(bus.resp_data), 14);
      check("t4_no_accept", 64'(bus.req_ready), 0);
      cyc();
    end
    auto_unit      = 1;
    bus.resp_ready = 2'b11;
    wait_idle(100);
    auto_unit = 0;

    // Reset while waiting for the unit.
    cyc();
    bus.unit_ready         = 1'b1;
    bus.unit_valid         = 1'b0;
    bus.resp_ready         = 2'b00;
    bus.req_valid          = 2'b01;
    bus.req_op[0 +: OPW]   = OpDiv;
    bus.req_a[0 +: WIDTH]  = 32'd100;
    bus.req_b[0 +: WIDTH]  = 32'd3;
    cyc();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t5_uiv", 64'(bus.unit_input_valid), 1);
    cyc();
    bus.unit_ready = 1'b0;
    reset          = 1'b1;
    @(negedge clk);
    check("t5_in_wait", 64'(bus.unit_output_ready), 1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t5_uor_cleared", 64'(bus.unit_output_ready), 0);
    check("t5_uiv_cleared", 64'(bus.unit_input_valid), 0);
    check("t5_unit_a_cleared", 64'(bus.unit_a), 0);
    check("t5_unit_b_cleared", 64'(bus.unit_b), 0);
    check("t5_unit_op_cleared", 64'(bus.unit_op), 0);
    check("t5_resp_data_cleared", 64'(bus.resp_data), 0);
    cyc();
    bus.unit_valid  = 1'b1;
    bus.unit_result = 32'd33;
    bus.resp_ready  = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_no_resp", 64'(bus.resp_valid), 0);
      cyc();
    end
    @(negedge clk);
    check("t5_no_late_data", 64'(bus.resp_data), 0);

    // Stray unit result while idle.
    cyc();
    bus.unit_result = 32'h0000_dead;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_data_zero", 64'(bus.resp_data), 0);
      check("t6_no_resp", 64'(bus.resp_valid), 0);
      cyc();
    end
    bus.unit_valid = 1'b0;

    // Both requesters always pending: strict alternation from requester 0.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    grant_log.delete();
    cyc();
    always_on = 1;
    auto_req  = 1;
    auto_unit = 1;
    for (int k = 0; k < 200 && grant_log.size() < 4; k++) cyc();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_grant%0d", k), 64'((k < grant_log.size()) ? grant_log[k] : -1),
            64'(k % 2));
    end

    // Random traffic with occasional resets.
    always_on = 0;
    for (int r = 0; r < 3; r++) begin
      repeat (800) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
    end
    repeat (400) cyc();

    auto_req       = 0;
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    wait_idle(200);
    auto_unit = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_arbiter.md
# mdu_arbiter

Shares one multi-cycle execution unit (multiply/divide) between `NREQ` requesters using valid/ready handshakes on both sides. A round-robin arbiter selects one requester, latches its operation, issues it to the unit, waits for the result, and returns it to the same requester. Only one operation is in flight at a time. The block sits between the issue logic and the shared unit, whose ports follow the team's `unit_ready`/`unit_valid` convention.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (≥2).
- `WIDTH`, 32: operand and result width.
- `OPW`, 3: opcode width.

Ports:
- `clk` in 1: single clock; everything updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_ready` out NREQ: one-hot accept.
- `req_op` in NREQ*OPW: per-requester opcode, packed with requester i in slice i.
- `req_a`, `req_b` in NREQ*WIDTH: per-requester operands, packed.
- `resp_valid` out NREQ: one-hot result valid.
- `resp_ready` in NREQ: per-requester result accept.
- `resp_data` out WIDTH: result, shared by all requesters and qualified by `resp_valid`.
- `unit_input_valid` out 1: operation presented to the unit.
- `unit_ready` in 1: unit accepts the operation.
- `unit_op` out OPW, `unit_a`/`unit_b` out WIDTH: latched payload.
- `unit_valid` in 1: unit result valid.
- `unit_output_ready` out 1: arbiter accepts the result.
- `unit_result` in WIDTH: unit result.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `RESPOND`.
- **IDLE**
  - Round-robin pick among the set `req_valid` bits. Search starts at `last_grant+1` and wraps modulo `NREQ`.
  - `req_ready` is combinational: one-hot at the picked index, and only in IDLE.
  - On a transfer (`req_valid[g] && req_ready[g]`): latch `g`, op, a and b; go to ISSUE.
  - No request pending: stay in IDLE, `req_ready` = 0.
- **ISSUE**
  - `unit_input_valid` = 1 with the latched payload held stable.
  - On `unit_ready`: go to WAIT.
  - Otherwise hold: payload and `unit_input_valid` stay steady.
- **WAIT**
  - `unit_output_ready` = 1.
  - On `unit_valid`: latch `unit_result` into `resp_data`; go to RESPOND.
- **RESPOND**
  - `resp_valid[g]` = 1; `resp_data` is held stable.
  - On `resp_ready[g]`: `last_grant <= g`; go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- Requests arriving during ISSUE, WAIT or RESPOND stall, with `req_ready` = 0. The requester keeps its payload stable.
- `unit_valid` outside WAIT is ignored and never latched.
- Fairness: a requester that holds `req_valid` is granted within `NREQ` transactions.

## Timing
- Reset values:
  - state = IDLE.
  - `last_grant` = `NREQ-1`, so requester 0 wins first.
  - `req_ready`, `resp_valid`, `unit_input_valid`, `unit_output_ready` = 0.
  - `resp_data`, `unit_op`, `unit_a`, `unit_b` = 0.
- `unit_input_valid`, `unit_output_ready` and `resp_valid` are decoded from registered state only; they have no combinational path from inputs.
- Best-case sequence, unit answering in one cycle:
  - cycle 0: accept.
  - cycle 1: issue (`unit_ready` = 1).
  - cycle 2: WAIT (`unit_valid` = 1).
  - cycle 3: `resp_valid`.
  - cycle 4: IDLE, next accept possible.
- Minimum 4 cycles per transaction.
- A response taken in cycle N allows a new accept in cycle N+1. There is no same-cycle back-to-back accept.
- Reset mid-operation (any state): return to IDLE with reset values next cycle. The in-flight operation is dropped and its requester is not notified.
- Only `reset` takes priority over the FSM transitions.

## Structure
- Package `mdu_pkg`:
  - `mdu_state_t` enum (IDLE/ISSUE/WAIT/RESPOND).
  - `OPW` default.
  - Opcode localparams: MUL, MULH, DIV, DIVU, REM, REMU.
- Sub-module `rr_pick`:
  - Combinational round-robin picker, parameterized by `NREQ`.
  - Inputs: request vector, `last_grant`.
  - Outputs: one-hot grant, index, `any`.

## Test plan
- Reset, then `req_valid`=2'b01 with op=MUL, a=6, b=7; unit answers 42 one cycle after issue. Expect `req_ready`=01 in cycle 0, `unit_input_valid` in cycle 1, `resp_valid`=01 with `resp_data`=42 in cycle 3.
- Both requesters hold valid for 4 transactions. Expect grants in order 0,1,0,1.
- `unit_ready` held low for 5 cycles in ISSUE. Expect `unit_input_valid`=1 and `unit_a`/`unit_b` unchanged throughout; no `req_ready`.
- `resp_ready[g]`=0 for 3 cycles. Expect `resp_valid` and `resp_data` held, and no second accept. `resp_ready` from the non-granted requester does not release the response.
- Assert `reset` during WAIT with a=100, b=3 in flight. Next cycle: all outputs 0 and state IDLE. A later `unit_valid` produces no `resp_valid`.
- Stray `unit_valid`=1 with `unit_result`=0xDEAD while in IDLE. Expect `resp_data` to remain 0 and no `resp_valid`.
